// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: six-digit seven-segment controller. One shared hex decoder
// is time-multiplexed round-robin over the digits, and each decoded pattern is
// latched into that digit's registered HEX output.
module hex_display_ctrl #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_blank,
  input  logic [5:0] blink_mask,
  output logic [3:0] dec_in,
  input  logic [6:0] dec_out,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned PTR_W      = 3;
  localparam int unsigned PRE_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF   = 7'h7F;
  localparam logic [PTR_W-1:0] PTR_LAST  = 3'd5;
  localparam logic [2:0]       ADDR_CLR  = 3'd6;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DIGIT_W-1:0]      digit_q [NUM_DIGITS];
  logic [DIGIT_W-1:0]      digit_d [NUM_DIGITS];
  logic [SEG_W-1:0]        hex_q   [NUM_DIGITS];
  logic [SEG_W-1:0]        hex_d   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d, ptr_nxt;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic                    phase_q, phase_d;

  assign wr_ready = (state_q == RUN);
  assign dec_in   = digit_q[ptr_q];
  assign ptr_nxt  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

  // Next-state: blink prescaler, scan/load of the current digit, writes and clear sweep
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    hex_d   = hex_q;
    blank_d = blank_q;
    ptr_d   = ptr_q;
    pre_d   = pre_q + PRE_W'(1);
    phase_d = phase_q;

    if (pre_q == PRE_MAX) begin
      pre_d   = '0;
      phase_d = ~phase_q;
    end

    case (state_q)
      RUN: begin
        // Scan load uses pre-write digit/blank, so a write to ptr shows on the next visit
        if (blank_q[ptr_q] || (blink_mask[ptr_q] && phase_q)) begin
          hex_d[ptr_q] = SEG_OFF;
        end else begin
          hex_d[ptr_q] = dec_out;
        end
        ptr_d = ptr_nxt;
        if (wr_valid) begin
          if (wr_addr < ADDR_CLR) begin
            digit_d[wr_addr] = wr_data;
            blank_d[wr_addr] = wr_blank;
          end else if (wr_addr == ADDR_CLR) begin
            ptr_d   = '0;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        digit_d[ptr_q] = '0;
        blank_d[ptr_q] = 1'b1;
        hex_d[ptr_q]   = SEG_OFF;
        ptr_d          = ptr_nxt;
        if (ptr_q == PTR_LAST) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      digit_q <= '{default: '0};
      hex_q   <= '{default: SEG_OFF};
      blank_q <= '1;
      ptr_q   <= '0;
      pre_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      hex_q   <= hex_d;
      blank_q <= blank_d;
      ptr_q   <= ptr_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

endmodule
